// File: rtl/pa_iu_div_pkg.sv
// ---------------------------------------------------------------------------
// pa_iu_div_pkg
// Shared integer-unit definitions used by the divider:
//   - divider FSM state encodings
//   - special result constants for divide-by-zero and signed overflow
//   - helper that returns the operand magnitude for signed or unsigned forms
// ---------------------------------------------------------------------------
package pa_iu_div_pkg;

    // Divider FSM encodings.
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // Special-value constants.
    localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_INT_MIN  = 32'h8000_0000;

    // Number of radix-2 steps minus one; loaded into the counter on accept.
    localparam logic [4:0]  DIV_LAST_STEP = 5'd31;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] divMagnitude(input logic [31:0] value,
                                                 input logic        isSigned);
        logic [31:0] mag;
        mag = value;
        if (isSigned && value[31]) begin
            mag = ~value + 32'd1;
        end
        return mag;
    endfunction

endpackage : pa_iu_div_pkg

// File: rtl/pa_iu_div_gated_clk_cell.sv
// ---------------------------------------------------------------------------
// gated_clk_cell
// Latch-based integrated clock gate. The enable is captured while the input
// clock is low so the gated clock never glitches.
// Ports:
//   clk_in             - free-running clock
//   global_en          - chip-level clock enable
//   module_en          - module-level enable (forces the clock on)
//   local_en           - functional enable from the owning block
//   external_en        - unconditional enable
//   pad_yy_icg_scan_en - scan bypass, keeps the clock running in test mode
//   clk_out            - gated clock
// ---------------------------------------------------------------------------
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clkEnBfLatch;
    logic clkEnAfLatch;

    assign clkEnBfLatch = (global_en & (module_en | local_en))
                        | external_en
                        | pad_yy_icg_scan_en;

    // Transparent while the clock is low; holds steady across the high phase.
    always_latch begin
        if (!clk_in) begin
            clkEnAfLatch <= clkEnBfLatch;
        end
    end

    assign clk_out = clk_in & clkEnAfLatch;

endmodule : gated_clk_cell

// File: rtl/pa_iu_div.sv
// ---------------------------------------------------------------------------
// pa_iu_div
// Iterative 32-bit integer divider for DIV/DIVU/REM/REMU. One restoring
// radix-2 step per cycle (32 cycles); divide-by-zero and signed overflow
// bypass the iteration and finish one cycle after accept.
// Ports:
//   forever_cpuclk       - core clock
//   cpurst_b             - asynchronous active-low reset
//   cp0_yy_clk_en        - global clock-gate enable
//   cp0_iu_icg_en        - module clock-gate enable
//   pad_yy_icg_scan_en   - scan bypass for the clock gate
//   idu_iu_ex1_inst_vld  - EX1 instruction valid
//   idu_iu_ex1_div_sel   - EX1 instruction is a divide
//   idu_iu_ex1_func      - [0] signed operands, [1] return remainder
//   idu_iu_ex1_src0      - dividend
//   idu_iu_ex1_src1      - divisor
//   rtu_iu_flush         - kill any in-flight divide
//   div_dp_ex1_stall     - hold EX1 while the divide is not finished
//   div_dp_ex1_cmplt     - divide retires this cycle
//   div_dp_wb_vld        - result valid pulse
//   div_dp_wb_rslt       - quotient or remainder
// ---------------------------------------------------------------------------
module pa_iu_div
    import pa_iu_div_pkg::*;
(
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        cp0_yy_clk_en,
    input  logic        cp0_iu_icg_en,
    input  logic        pad_yy_icg_scan_en,
    input  logic        idu_iu_ex1_inst_vld,
    input  logic        idu_iu_ex1_div_sel,
    input  logic [1:0]  idu_iu_ex1_func,
    input  logic [31:0] idu_iu_ex1_src0,
    input  logic [31:0] idu_iu_ex1_src1,
    input  logic        rtu_iu_flush,
    output logic        div_dp_ex1_stall,
    output logic        div_dp_ex1_cmplt,
    output logic        div_dp_wb_vld,
    output logic [31:0] div_dp_wb_rslt
);

    // Control state (free-running clock, reset)
    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;

    // Datapath state (gated clock, not reset)
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        funcRem_q, funcRem_d;
    logic        quoNeg_q, quoNeg_d;
    logic        remNeg_q, remNeg_d;

    logic        divReq;
    logic        accept;
    logic        byZero;
    logic        overflow;
    logic        divClk;
    logic        divClkEn;

    logic [32:0] shifted;
    logic [32:0] trialDiff;
    logic        quoBit;
    logic [31:0] quoRes;
    logic [31:0] remRes;

    assign divReq   = idu_iu_ex1_inst_vld & idu_iu_ex1_div_sel;
    assign accept   = (state_q == DIV_IDLE) & divReq & ~rtu_iu_flush;
    assign byZero   = (idu_iu_ex1_src1 == 32'd0);
    assign overflow = idu_iu_ex1_func[0]
                    & (idu_iu_ex1_src0 == DIV_INT_MIN)
                    & (idu_iu_ex1_src1 == DIV_ALL_ONES);

    // -----------------------------------------------------------------------
    // Next-state logic. Flush wins over everything and always returns to
    // IDLE; special operands skip the iteration entirely.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rtu_iu_flush) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (accept) begin
                        if (byZero || overflow) begin
                            state_d = DIV_DONE;
                        end else begin
                            state_d = DIV_CALC;
                            cnt_d   = DIV_LAST_STEP;
                        end
                    end
                end
                DIV_CALC: begin
                    if (cnt_q == 5'd0) begin
                        state_d = DIV_DONE;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= DIV_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath clock only runs while a divide is being accepted or is busy.
    // -----------------------------------------------------------------------
    assign divClkEn = accept | (state_q != DIV_IDLE);

    gated_clk_cell x_div_clk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_iu_icg_en),
        .local_en           (divClkEn),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (divClk)
    );

    // Restoring step: the dividend lives in the quotient register and is
    // shifted out MSB-first while quotient bits are shifted in at the LSB.
    // rem_q[32] is the bit that falls off the top of the shift; if set, the
    // shifted value is certainly no smaller than the divisor.
    assign shifted   = {rem_q[31:0], quo_q[31]};
    assign trialDiff = shifted - {1'b0, dvsr_q};
    assign quoBit    = rem_q[32] | (shifted >= {1'b0, dvsr_q});

    // -----------------------------------------------------------------------
    // Datapath next values. Special operands preload the final quotient and
    // remainder with both signs cleared, so DONE uses one result path.
    // -----------------------------------------------------------------------
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        funcRem_d = funcRem_q;
        quoNeg_d  = quoNeg_q;
        remNeg_d  = remNeg_q;
        if (accept) begin
            funcRem_d = idu_iu_ex1_func[1];
            if (byZero) begin
                quo_d    = DIV_ALL_ONES;
                rem_d    = {1'b0, idu_iu_ex1_src0};
                quoNeg_d = 1'b0;
                remNeg_d = 1'b0;
            end else if (overflow) begin
                quo_d    = DIV_INT_MIN;
                rem_d    = 33'd0;
                quoNeg_d = 1'b0;
                remNeg_d = 1'b0;
            end else begin
                quo_d    = divMagnitude(idu_iu_ex1_src0, idu_iu_ex1_func[0]);
                dvsr_d   = divMagnitude(idu_iu_ex1_src1, idu_iu_ex1_func[0]);
                rem_d    = 33'd0;
                quoNeg_d = (idu_iu_ex1_src0[31] ^ idu_iu_ex1_src1[31])
                         & idu_iu_ex1_func[0];
                remNeg_d = idu_iu_ex1_src0[31] & idu_iu_ex1_func[0];
            end
        end else if (state_q == DIV_CALC) begin
            rem_d = quoBit ? trialDiff : shifted;
            quo_d = {quo_q[30:0], quoBit};
        end
    end

    always_ff @(posedge divClk) begin
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        dvsr_q    <= dvsr_d;
        funcRem_q <= funcRem_d;
        quoNeg_q  <= quoNeg_d;
        remNeg_q  <= remNeg_d;
    end

    // Result is a pure function of registers that stop changing once the
    // divider returns to IDLE, so it holds its value between operations.
    assign quoRes = quoNeg_q ? (~quo_q + 32'd1) : quo_q;
    assign remRes = remNeg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

    assign div_dp_wb_rslt   = funcRem_q ? remRes : quoRes;
    assign div_dp_wb_vld    = (state_q == DIV_DONE) & ~rtu_iu_flush;
    assign div_dp_ex1_cmplt = div_dp_wb_vld;
    assign div_dp_ex1_stall = divReq & (state_q != DIV_DONE) & ~rtu_iu_flush;

endmodule : pa_iu_div

// File: tb/tb_pa_iu_div.sv
// ---------------------------------------------------------------------------
// tb_pa_iu_div
// Directed and random divides against a reference model; expected results
// are queued on issue and popped when the divider raises its result valid.
// ---------------------------------------------------------------------------
module tb_pa_iu_div;

    logic        clock;
    logic        cpuRstB;
    logic        clkEn;
    logic        icgEn;
    logic        scanEn;
    logic        instVld;
    logic        divSel;
    logic [1:0]  func;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        flush;
    logic        stall;
    logic        cmplt;
    logic        wbVld;
    logic [31:0] wbRslt;

    int          passCount = 0;
    int          checkCount = 0;
    logic [31:0] expQ[$];

    pa_iu_div dut (
        .forever_cpuclk      (clock),
        .cpurst_b            (cpuRstB),
        .cp0_yy_clk_en       (clkEn),
        .cp0_iu_icg_en       (icgEn),
        .pad_yy_icg_scan_en  (scanEn),
        .idu_iu_ex1_inst_vld (instVld),
        .idu_iu_ex1_div_sel  (divSel),
        .idu_iu_ex1_func     (func),
        .idu_iu_ex1_src0     (src0),
        .idu_iu_ex1_src1     (src1),
        .rtu_iu_flush        (flush),
        .div_dp_ex1_stall    (stall),
        .div_dp_ex1_cmplt    (cmplt),
        .div_dp_wb_vld       (wbVld),
        .div_dp_wb_rslt      (wbRslt)
    );

    // Free-running core clock, 10 time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference divide with RISC-V style special cases.
    function automatic logic [31:0] modelDiv(input logic [1:0]  f,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f[1] ? 32'd0 : 32'h8000_0000;
        if (f[0]) begin
            sa = $signed(a);
            sb = $signed(b);
            return f[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    function automatic int modelLatency(input logic [1:0]  f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Issue one divide in the current cycle (cycle 0), hold EX1 valid until
    // the result comes back, and check handshake outputs every cycle.
    task automatic applyStimulus(input logic [1:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
        int lat;
        lat = modelLatency(f, a, b);
        expQ.push_back(modelDiv(f, a, b));
        instVld = 1'b1;
        divSel  = 1'b1;
        func    = f;
        src0    = a;
        src1    = b;
        for (int c = 0; c <= lat + 2; c++) begin
            @(negedge clock);
            checkOutput($sformatf("wb_vld c%0d", c), {31'd0, wbVld}, {31'd0, c == lat});
            checkOutput($sformatf("cmplt c%0d", c), {31'd0, cmplt}, {31'd0, c == lat});
            checkOutput($sformatf("stall c%0d", c), {31'd0, stall}, {31'd0, c < lat});
            if (wbVld) begin
                if (expQ.size() > 0) begin
                    checkOutput($sformatf("rslt f%0d %h/%h", f, a, b), wbRslt, expQ.pop_front());
                end else begin
                    checkOutput("unexpected wb", 32'd1, 32'd0);
                end
            end
            nextCycle();
            if (c == lat) begin
                instVld = 1'b0;
                divSel  = 1'b0;
            end
        end
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        expQ.delete();
    endtask

    initial begin
        logic [1:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        cpuRstB = 1'b0;
        clkEn   = 1'b1;
        icgEn   = 1'b0;
        scanEn  = 1'b0;
        instVld = 1'b0;
        divSel  = 1'b0;
        func    = 2'b00;
        src0    = 32'd0;
        src1    = 32'd0;
        flush   = 1'b0;

        // Reset state
        #2;
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        checkOutput("reset wb_vld", {31'd0, wbVld}, 32'd0);
        checkOutput("reset cmplt", {31'd0, cmplt}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        cpuRstB = 1'b1;
        nextCycle();

        // Directed operations
        applyStimulus(2'b00, 32'd100, 32'd7);
        applyStimulus(2'b10, 32'd100, 32'd7);
        applyStimulus(2'b01, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(2'b01, 32'd5, 32'd0);
        applyStimulus(2'b11, 32'd5, 32'd0);
        applyStimulus(2'b11, 32'hFFFF_FFFB, 32'd0);
        applyStimulus(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(2'b11, 32'd7, 32'hFFFF_FFFE);
        applyStimulus(2'b10, 32'd3, 32'd10);

        // Random operations
        for (int i = 0; i < 8; i++) begin
            rf = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            applyStimulus(rf, ra, rb);
        end

        // Flush in cycle 10 of a DIVU, then a new DIVU in cycle 11
        instVld = 1'b1;
        divSel  = 1'b1;
        func    = 2'b00;
        src0    = 32'd1000;
        src1    = 32'd7;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            checkOutput($sformatf("pre-flush stall c%0d", c), {31'd0, stall}, 32'd1);
            checkOutput($sformatf("pre-flush wb_vld c%0d", c), {31'd0, wbVld}, 32'd0);
            nextCycle();
        end
        flush = 1'b1;
        @(negedge clock);
        checkOutput("flush stall", {31'd0, stall}, 32'd0);
        checkOutput("flush wb_vld", {31'd0, wbVld}, 32'd0);
        nextCycle();
        flush = 1'b0;
        applyStimulus(2'b00, 32'd9, 32'd3);

        // Reset pulsed in cycle 20 of a divide
        instVld = 1'b1;
        divSel  = 1'b1;
        func    = 2'b00;
        src0    = 32'hFFFF_FFFF;
        src1    = 32'd3;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            checkOutput($sformatf("pre-reset stall c%0d", c), {31'd0, stall}, 32'd1);
            nextCycle();
        end
        instVld = 1'b0;
        divSel  = 1'b0;
        cpuRstB = 1'b0;
        #1;
        checkOutput("mid reset stall", {31'd0, stall}, 32'd0);
        checkOutput("mid reset wb_vld", {31'd0, wbVld}, 32'd0);
        checkOutput("mid reset cmplt", {31'd0, cmplt}, 32'd0);
        @(negedge clock);
        cpuRstB = 1'b1;
        nextCycle();
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            checkOutput($sformatf("post-reset wb_vld c%0d", c), {31'd0, wbVld}, 32'd0);
            nextCycle();
        end
        applyStimulus(2'b10, 32'd1000, 32'd7);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_pa_iu_div
